piezo_note_scheduler: RTL

//  Arbitrates and sequences sound requests (coin inserted: 100w/500w/1000w;

---
 rtl/piezo_pkg.sv | 27 ++
 rtl/piezo_req_prio_enc.sv | 28 ++
 rtl/piezo_note_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/piezo_pkg.sv
// -----------------------------------------------------------------------------
// piezo_pkg
//   Shared definitions for the piezo sound path: note codes understood by the
//   tone generator, the scheduler FSM state encoding, and request vector width.
//   Imported by the vending FSM, the scheduler and the tone generator.
// -----------------------------------------------------------------------------
package piezo_pkg;

    localparam int NUM_REQ = 6;

    typedef logic [2:0] note_code_t;

    localparam note_code_t NOTE_NONE  = 3'd0;
    localparam note_code_t NOTE_100W  = 3'd1;
    localparam note_code_t NOTE_500W  = 3'd2;
    localparam note_code_t NOTE_1000W = 3'd3;
    localparam note_code_t NOTE_PROD1 = 3'd4;
    localparam note_code_t NOTE_PROD2 = 3'd5;
    localparam note_code_t NOTE_PROD3 = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/piezo_req_prio_enc.sv
// -----------------------------------------------------------------------------
// piezo_req_prio_enc
//   Combinational priority encoder over latched sound requests. The highest
//   set bit wins; bit i maps to note code i+1.
// Ports:
//   pend_i   in   NUM_REQ  latched requests
//   valid_o  out  1        any request present
//   code_o   out  3        note code of the winning request (0 if none)
// -----------------------------------------------------------------------------
module piezo_req_prio_enc
    import piezo_pkg::*;
(
    input  logic [NUM_REQ-1:0] pend_i,
    output logic               valid_o,
    output note_code_t         code_o
);

    always_comb begin
        code_o = NOTE_NONE;
        // Ascending scan: later (higher) bits overwrite lower ones.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_i[i]) code_o = note_code_t'(i + 1);
        end
    end

    assign valid_o = |pend_i;

endmodule

// File: rtl/piezo_note_scheduler.sv
// -----------------------------------------------------------------------------
// piezo_note_scheduler
//   Latches one-cycle sound request pulses, grants the highest pending code,
//   drives the tone datapath for PLAY_LEN cycles, then holds GAP_LEN silent
//   cycles before the next grant.
//   Optional build macro PIEZO_PREEMPT_EN: a higher pending code aborts the
//   tone currently playing (no done pulse, no gap, aborted code not re-queued).
// Ports:
//   clk_i         in   1      system clock, rising edge
//   rst_ni        in   1      asynchronous reset, active low
//   req_i         in   6      request pulses; bit i requests code i+1
//   note_state_o  out  3      code now playing; 0 = silent
//   note_cnt_o    out  CNT_W  cycles elapsed in current tone; 0 when silent
//   busy_o        out  1      high in PLAY or GAP
//   done_o        out  1      pulse on the last PLAY cycle of a completed tone
//   pending_o     out  6      latched, not-yet-granted requests
// -----------------------------------------------------------------------------
module piezo_note_scheduler
    import piezo_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PLAY_LEN = 400000,
    parameter int GAP_LEN  = 50000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output note_code_t         note_state_o,
    output logic [CNT_W-1:0]   note_cnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [NUM_REQ-1:0] pending_o
);

    localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(PLAY_LEN - 1);
    // Unreachable when GAP_LEN==0 (GAP is skipped); clamp keeps it non-negative.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_e               state_q, state_d;
    note_code_t           note_state_q, note_state_d;
    logic [CNT_W-1:0]     note_cnt_q, note_cnt_d;
    logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d;
    logic [NUM_REQ-1:0]   grant_mask;
    logic                 grant;
    logic                 enc_valid;
    note_code_t           enc_code;
    logic                 preempt;
    logic                 play_last;

    piezo_req_prio_enc u_prio_enc (
        .pend_i  (pend_q),
        .valid_o (enc_valid),
        .code_o  (enc_code)
    );

    assign play_last = (state_q == S_PLAY) && (note_cnt_q == PLAY_LAST);

`ifdef PIEZO_PREEMPT_EN
    assign preempt = (state_q == S_PLAY) && enc_valid && (enc_code > note_state_q);
`else
    assign preempt = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            note_state_q <= NOTE_NONE;
            note_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            note_state_q <= note_state_d;
            note_cnt_q   <= note_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            pend_q       <= pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        note_state_d = note_state_q;
        note_cnt_d   = note_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enc_valid) begin
                    grant        = 1'b1;
                    state_d      = S_PLAY;
                    note_state_d = enc_code;
                    note_cnt_d   = '0;
                end
            end
            S_PLAY: begin
                if (preempt) begin
                    grant        = 1'b1;
                    note_state_d = enc_code;
                    note_cnt_d   = '0;
                end else if (play_last) begin
                    note_state_d = NOTE_NONE;
                    note_cnt_d   = '0;
                    gap_cnt_d    = '0;
                    state_d      = (GAP_LEN == 0) ? S_IDLE : S_GAP;
                end else begin
                    note_cnt_d   = note_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                note_state_d = NOTE_NONE;
                note_cnt_d   = '0;
                gap_cnt_d    = '0;
            end
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            grant_mask[i] = grant && (enc_code == note_code_t'(i + 1));
        end
        // Set after clear: a re-request on the grant cycle stays pending.
        pend_d = (pend_q & ~grant_mask) | req_i;
    end

    // Output logic
    always_comb begin
        note_state_o = note_state_q;
        note_cnt_o   = note_cnt_q;
        busy_o       = (state_q != S_IDLE);
        done_o       = play_last && !preempt;
        pending_o    = pend_q;
    end

endmodule
